// File: rtl/apb_reg_completer_pkg.sv
// Shared types and constants for the APB register completer.
package apb_completer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam logic [31:0] ID_VALUE   = 32'hA9B3_0001;
    localparam int          NUM_REGS   = 16;
    localparam int          REG_IDX_W  = 4;
    localparam int          WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_reg_completer_if.sv
// APB bus bundle between a requester (master) and the register completer (slave).
interface apb_reg_completer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_completer_wait_counter.sv
// Wait-state down-counter; only compiled when APB_WAIT_STATE_EN is defined.
`ifdef APB_WAIT_STATE_EN
module apb_wait_counter
    import apb_completer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_value,
    output logic                  zero
);
    logic [WAIT_CNT_W-1:0] count_r;

    // Load on SETUP, otherwise count down to zero and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WAIT_CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {WAIT_CNT_W{1'b0}}) begin
            count_r <= count_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count_r == {WAIT_CNT_W{1'b0}});
endmodule
`endif

// File: rtl/apb_reg_completer.sv
// APB completer with 16 x 32-bit registers; register 0 is a read-only ID.
// Wait states are inserted only when APB_WAIT_STATE_EN is defined.
module apb_reg_completer
    import apb_completer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_reg_completer_if.slave apb
);
    apb_state_e              state_r;
    logic [ADDR_WIDTH-1:0]   lat_addr_r;
    logic                    lat_write_r;
    logic [DATA_WIDTH-1:0]   lat_wdata_r;
    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];

    logic                    setup_s;
    logic                    pready_s;
    logic                    err_s;
    logic                    complete_s;
    logic                    commit_s;
    logic [REG_IDX_W-1:0]    lat_idx_s;
    logic [DATA_WIDTH-1:0]   rd_value_s;
    logic [DATA_WIDTH-1:0]   prdata_s;

    assign setup_s   = apb.PSEL && !apb.PENABLE;
    assign lat_idx_s = lat_addr_r[5:2];

`ifdef APB_WAIT_STATE_EN
    logic cnt_zero_s;

    apb_wait_counter u_wait_counter (
        .clk        (PCLK),
        .rst        (PRESET),
        .load       (setup_s),
        .load_value (WAIT_CNT_W'(WAIT_CYCLES)),
        .zero       (cnt_zero_s)
    );

    assign pready_s = (state_r == ST_ACCESS) && cnt_zero_s;
`else
    assign pready_s = (state_r == ST_ACCESS);
`endif

    // Error decode and read-data selection; live bus must still match the latched request.
    always_comb begin
        err_s = (lat_addr_r[1:0] != 2'b00)
             || ((lat_addr_r >> 3'd6) != {ADDR_WIDTH{1'b0}})
             || (lat_write_r && (lat_idx_s == {REG_IDX_W{1'b0}}))
             || (apb.PADDR != lat_addr_r)
             || (apb.PWRITE != lat_write_r);
        if (lat_idx_s == {REG_IDX_W{1'b0}}) begin
            rd_value_s = DATA_WIDTH'(ID_VALUE);
        end else begin
            rd_value_s = regs_r[lat_idx_s];
        end
        if (pready_s && !err_s && !lat_write_r) begin
            prdata_s = rd_value_s;
        end else begin
            prdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign complete_s = (state_r == ST_ACCESS) && apb.PSEL && apb.PENABLE && pready_s;
    assign commit_s   = complete_s && lat_write_r && !err_s;

    // Transfer FSM, request latches and register file.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r     <= ST_IDLE;
            lat_addr_r  <= {ADDR_WIDTH{1'b0}};
            lat_write_r <= 1'b0;
            lat_wdata_r <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (setup_s) begin
                lat_addr_r  <= apb.PADDR;
                lat_write_r <= apb.PWRITE;
                lat_wdata_r <= apb.PWDATA;
            end
            if (commit_s) begin
                regs_r[lat_idx_s] <= lat_wdata_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (setup_s) begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A re-SETUP while in ACCESS keeps the FSM here with fresh latches.
                    if (!apb.PSEL || complete_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign apb.PREADY  = pready_s;
    assign apb.PSLVERR = pready_s && err_s;
    assign apb.PRDATA  = prdata_s;
endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench: the driver queues expected responses, a monitor checks each completion.
module tb_apb_reg_completer;
    import apb_completer_pkg::*;

`ifdef APB_WAIT_STATE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic PCLK;
    logic PRESET;
    apb_reg_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_reg_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus)
    );

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    int   setup_cyc = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard at every completing ACCESS cycle.
    always @(negedge PCLK) begin
        exp_t e;
        cyc++;
        if (!PRESET) begin
            if (bus.PSEL && !bus.PENABLE) setup_cyc = cyc;
            if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'(bus.PREADY), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("prdata", bus.PRDATA, e.rdata);
                    check("pslverr", 32'(bus.PSLVERR), 32'(e.err));
                    check("latency", 32'(cyc - setup_cyc + 1), 32'(LAT));
                end
            end
        end
    end

    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input logic flip);
        int n;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wdata;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        if (flip) bus.PADDR = addr ^ 8'h04;
        n = 0;
        forever begin
            @(negedge PCLK);
            if (bus.PREADY) break;
            n++;
            if (n > 20) begin
                check("ready_timeout", 32'(n), 32'h0);
                break;
            end
        end
        @(posedge PCLK); #1;
    endtask

    task automatic idle();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 32'h0;
        #12;
        check("rst_pready", 32'(bus.PREADY), 32'h0);
        check("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
        check("rst_prdata", bus.PRDATA, 32'h0);
        @(posedge PCLK); #1 PRESET = 1'b0;
        @(posedge PCLK); #1;

        xfer(1'b1, 8'h08, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        idle();
        xfer(1'b0, 8'h00, 32'h0, 32'hA9B3_0001, 1'b0, 1'b0);
        xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 32'hA9B3_0001, 1'b0, 1'b0);
        xfer(1'b1, 8'h42, 32'h0000_0055, 32'h0, 1'b1, 1'b0);
        xfer(1'b1, 8'h0A, 32'h0000_0077, 32'h0, 1'b1, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        xfer(1'b0, 8'h40, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

`ifdef APB_WAIT_STATE_EN
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h0C; bus.PWDATA = 32'hDEAD_BEEF;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_pready_c2", 32'(bus.PREADY), 32'h0);
        @(posedge PCLK); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK);
        check("abort_pready_c3", 32'(bus.PREADY), 32'h0);
        @(posedge PCLK); #1;
        xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, 1'b0);
        idle();
`endif

        xfer(1'b1, 8'h04, 32'h1111_1111, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 8'h08, 32'h2222_2222, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 8'h0C, 32'h3333_3333, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 8'h04, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 32'h2222_2222, 1'b0, 1'b0);
        xfer(1'b0, 8'h0C, 32'h0, 32'h3333_3333, 1'b0, 1'b0);
        idle();

        // Address changes between SETUP and ACCESS: errored, nothing written.
        xfer(1'b1, 8'h10, 32'h0000_AAAA, 32'h0, 1'b1, 1'b1);
        xfer(1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b1, 8'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 8'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        xfer(1'b1, 8'h14, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 8'h14, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h14;
        @(posedge PCLK); #1 bus.PENABLE = 1'b1;
        #1 PRESET = 1'b1;
        #1;
        check("midrst_pready", 32'(bus.PREADY), 32'h0);
        check("midrst_pslverr", 32'(bus.PSLVERR), 32'h0);
        check("midrst_prdata", bus.PRDATA, 32'h0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESET = 1'b0;
        @(posedge PCLK); #1;
        xfer(1'b0, 8'h14, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 8'h00, 32'h0, 32'hA9B3_0001, 1'b0, 1'b0);
        idle();
        idle();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
